// File: rtl/irq_pc_ctrl_if.sv
// Interface bundling the interrupt controller's decoder strobes, request
// lines and PC-sequencing outputs between the CPU core and irq_pc_ctrl.
interface irq_pc_ctrl_if #(
   parameter int ID_W     = 2,
   parameter int PC_WIDTH = 10
);
   localparam int NUM_IRQ = 2**ID_W;

   logic [NUM_IRQ-1:0]  irq;
   logic                mask_we;
   logic [NUM_IRQ-1:0]  mask_d;
   logic                ie_set;
   logic                ie_clr;
   logic                reti;
   logic [PC_WIDTH-1:0] pc_next;

   logic                int_take;
   logic [PC_WIDTH-1:0] int_vector;
   logic                ret_take;
   logic [PC_WIDTH-1:0] ret_pc;
   logic                in_service;
   logic [ID_W-1:0]     active_id;
   logic [NUM_IRQ-1:0]  pending;
   logic [NUM_IRQ-1:0]  mask;
   logic                ie;

   modport master (
      output irq, mask_we, mask_d, ie_set, ie_clr, reti, pc_next,
      input  int_take, int_vector, ret_take, ret_pc, in_service,
             active_id, pending, mask, ie
   );

   modport slave (
      input  irq, mask_we, mask_d, ie_set, ie_clr, reti, pc_next,
      output int_take, int_vector, ret_take, ret_pc, in_service,
             active_id, pending, mask, ie
   );
endinterface

// File: rtl/irq_pc_ctrl.sv
// Single-level vectored interrupt controller: latches irq rising edges,
// redirects the PC to a per-line vector and restores the saved PC on reti.
module irq_pc_ctrl #(
   parameter int                  ID_W      = 2,
   parameter int                  PC_WIDTH  = 10,
   parameter logic [PC_WIDTH-1:0] VEC_BASE  = 10'h380,
   parameter int                  VEC_SHIFT = 4
) (
   input  logic         clk,
   input  logic         reset,
   irq_pc_ctrl_if.slave bus
);
   localparam int NUM_IRQ = 2**ID_W;

   typedef enum logic {IDLE, SERVICE} state_t;

   state_t              state, state_nx;
   logic [NUM_IRQ-1:0]  irq_d;
   logic [NUM_IRQ-1:0]  pending;
   logic [NUM_IRQ-1:0]  mask;
   logic                ie;
   logic [PC_WIDTH-1:0] ret_pc;
   logic [ID_W-1:0]     active_id;
   logic                in_service;

   logic [NUM_IRQ-1:0]  new_edge;
   logic [NUM_IRQ-1:0]  elig;
   logic [NUM_IRQ-1:0]  take_clr;
   logic [ID_W-1:0]     sel;
   logic                int_take;
   logic                ret_take;

   assign new_edge = bus.irq & ~irq_d;
   assign elig     = pending & ~mask;
   assign take_clr = int_take ? (NUM_IRQ'(1) << sel) : '0;

   // Lowest index wins: scan downward so the last hit is the lowest set bit.
   always_comb begin
      sel = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (elig[i]) sel = ID_W'(i);
      end
   end

   always_comb begin
      state_nx = state;
      int_take = 1'b0;
      ret_take = 1'b0;
      if (!reset) begin
         case (state)
            IDLE: begin
               if (ie && |elig) begin
                  int_take = 1'b1;
                  state_nx = SERVICE;
               end
            end
            SERVICE: begin
               if (bus.reti) begin
                  ret_take = 1'b1;
                  state_nx = IDLE;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         irq_d      <= '1;
         pending    <= '0;
         mask       <= '0;
         ie         <= 1'b0;
         ret_pc     <= '0;
         active_id  <= '0;
         in_service <= 1'b0;
      end else begin
         state   <= state_nx;
         irq_d   <= bus.irq;
         // A fresh edge on the line being taken survives the clear.
         pending <= (pending & ~take_clr) | new_edge;
         if (bus.mask_we) mask <= bus.mask_d;
         if (bus.ie_clr)      ie <= 1'b0;
         else if (bus.ie_set) ie <= 1'b1;
         if (int_take) begin
            ret_pc     <= bus.pc_next;
            active_id  <= sel;
            in_service <= 1'b1;
         end else if (ret_take) begin
            in_service <= 1'b0;
         end
      end
   end

   assign bus.int_take   = int_take;
   assign bus.int_vector = VEC_BASE + (PC_WIDTH'(sel) << VEC_SHIFT);
   assign bus.ret_take   = ret_take;
   assign bus.ret_pc     = ret_pc;
   assign bus.in_service = in_service;
   assign bus.active_id  = active_id;
   assign bus.pending    = pending;
   assign bus.mask       = mask;
   assign bus.ie         = ie;
endmodule

// File: tb/tb_irq_pc_ctrl.sv
// Directed bench for irq_pc_ctrl: expectations are queued as stimulus is
// applied and drained against the DUT outputs at each observation point.
module tb_irq_pc_ctrl;
   logic clk;
   logic reset;

   irq_pc_ctrl_if #(.ID_W(2), .PC_WIDTH(10)) bus ();

   irq_pc_ctrl #(
      .ID_W(2), .PC_WIDTH(10), .VEC_BASE(10'h380), .VEC_SHIFT(4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [31:0] observe(string tag);
      case (tag)
         "int_take":   return 32'(bus.int_take);
         "int_vector": return 32'(bus.int_vector);
         "ret_take":   return 32'(bus.ret_take);
         "ret_pc":     return 32'(bus.ret_pc);
         "in_service": return 32'(bus.in_service);
         "active_id":  return 32'(bus.active_id);
         "pending":    return 32'(bus.pending);
         "mask":       return 32'(bus.mask);
         "ie":         return 32'(bus.ie);
         default:      return 'x;
      endcase
   endfunction

   task automatic expect_val(string tag, logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sbq.push_back(e);
   endtask

   task automatic drain(string step);
      exp_t        e;
      logic [31:0] o;
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         o = observe(e.tag);
         checks++;
         assert (o === e.val) else begin
            errors++;
            $error("FAIL %s/%s observed=%0h expected=%0h", step, e.tag, o, e.val);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      reset       = 1'b1;
      bus.irq     = '0;
      bus.mask_we = 1'b0;
      bus.mask_d  = '0;
      bus.ie_set  = 1'b0;
      bus.ie_clr  = 1'b0;
      bus.reti    = 1'b0;
      bus.pc_next = '0;
      #12;

      // Reset state
      expect_val("in_service", 0); expect_val("ret_pc", 0); expect_val("pending", 0);
      expect_val("mask", 0); expect_val("ie", 0); expect_val("int_take", 0);
      expect_val("ret_take", 0); expect_val("active_id", 0);
      drain("reset");
      reset = 1'b0;
      tick();

      // Line 2 take and return-PC capture
      bus.ie_set = 1'b1;
      tick();
      bus.ie_set  = 1'b0;
      bus.irq     = 4'b0100;
      bus.pc_next = 10'h045;
      settle();
      expect_val("ie", 1); expect_val("int_take", 0);
      drain("t1_edge");
      tick();
      expect_val("pending", 4'b0100); expect_val("int_take", 1); expect_val("int_vector", 10'h3A0);
      drain("t1_take");
      tick();
      expect_val("in_service", 1); expect_val("active_id", 2); expect_val("ret_pc", 10'h045);
      expect_val("pending", 0); expect_val("int_take", 0);
      drain("t1_service");

      // Line 0 edge during service waits for reti
      bus.irq = 4'b0101;
      tick();
      expect_val("pending", 4'b0001); expect_val("int_take", 0);
      drain("t4_latched");
      tick();
      expect_val("int_take", 0); expect_val("in_service", 1);
      drain("t4_hold");
      bus.reti = 1'b1;
      settle();
      expect_val("ret_take", 1); expect_val("ret_pc", 10'h045); expect_val("int_take", 0);
      drain("t4_reti");
      tick();
      bus.reti = 1'b0;
      settle();
      expect_val("in_service", 0); expect_val("int_take", 1); expect_val("int_vector", 10'h380);
      drain("t4_b2b");
      tick();
      expect_val("active_id", 0); expect_val("pending", 0);
      drain("t4_line0");
      bus.reti = 1'b1;
      tick();
      settle();
      expect_val("ret_take", 0); expect_val("in_service", 0);
      drain("t4_reti_idle");
      tick();
      expect_val("in_service", 0); expect_val("int_take", 0);
      drain("t4_idle_stay");
      bus.reti = 1'b0;

      // Simultaneous lines 1 and 3: priority, then back-to-back after reti
      bus.irq = 4'b0000;
      tick();
      bus.irq     = 4'b1010;
      bus.pc_next = 10'h100;
      tick();
      expect_val("pending", 4'b1010); expect_val("int_take", 1); expect_val("int_vector", 10'h390);
      drain("t2_take1");
      tick();
      expect_val("active_id", 1); expect_val("pending", 4'b1000); expect_val("ret_pc", 10'h100);
      drain("t2_service1");
      bus.reti = 1'b1;
      settle();
      expect_val("ret_take", 1); expect_val("ret_pc", 10'h100);
      drain("t2_reti");
      tick();
      bus.reti = 1'b0;
      settle();
      expect_val("int_take", 1); expect_val("int_vector", 10'h3B0);
      drain("t2_take3");
      tick();
      expect_val("active_id", 3); expect_val("pending", 0);
      drain("t2_service3");
      bus.reti = 1'b1;
      tick();
      bus.reti = 1'b0;

      // Mask holds a pending line off until cleared
      bus.mask_we = 1'b1;
      bus.mask_d  = 4'b0001;
      bus.irq     = 4'b0000;
      tick();
      bus.mask_we = 1'b0;
      bus.irq     = 4'b0001;
      tick();
      expect_val("mask", 4'b0001); expect_val("pending", 4'b0001);
      drain("t3_masked");
      for (int k = 0; k < 5; k++) begin
         expect_val("int_take", 0); expect_val("pending", 4'b0001);
         drain("t3_hold");
         tick();
      end
      bus.mask_we = 1'b1;
      bus.mask_d  = 4'b0000;
      settle();
      expect_val("int_take", 0);
      drain("t3_mask_wr");
      tick();
      bus.mask_we = 1'b0;
      settle();
      expect_val("int_take", 1); expect_val("int_vector", 10'h380);
      drain("t3_unmasked");
      tick();
      bus.reti = 1'b1;
      tick();
      bus.reti = 1'b0;

      // ie_set/ie_clr priority and delayed enable
      bus.ie_set = 1'b1;
      bus.ie_clr = 1'b1;
      bus.irq    = 4'b0000;
      tick();
      bus.ie_set = 1'b0;
      bus.ie_clr = 1'b0;
      expect_val("ie", 0);
      drain("t5_clr_wins");
      bus.irq = 4'b0010;
      tick();
      expect_val("pending", 4'b0010); expect_val("int_take", 0);
      drain("t5_ie_off");
      bus.ie_set = 1'b1;
      settle();
      expect_val("int_take", 0);
      drain("t5_ie_same");
      tick();
      bus.ie_set  = 1'b0;
      bus.pc_next = 10'h123;
      settle();
      expect_val("int_take", 1); expect_val("int_vector", 10'h390);
      drain("t5_ie_next");
      tick();
      bus.irq = 4'b1010;
      tick();
      expect_val("in_service", 1); expect_val("ret_pc", 10'h123); expect_val("pending", 4'b1000);
      drain("t6_pre_reset");

      // Asynchronous reset mid-service with all lines held high
      bus.irq = 4'b1111;
      reset   = 1'b1;
      #2;
      expect_val("in_service", 0); expect_val("ret_pc", 0); expect_val("pending", 0);
      expect_val("ie", 0); expect_val("int_take", 0); expect_val("ret_take", 0);
      drain("t6_async");
      reset = 1'b0;
      tick();
      bus.ie_set = 1'b1;
      tick();
      bus.ie_set = 1'b0;
      tick();
      tick();
      expect_val("ie", 1); expect_val("pending", 0); expect_val("int_take", 0);
      drain("t6_held_high");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
